uart_rx_cfg: RTL and testbench

Parametrised, configurable UART receiver. It is the successor to the team's fixed 8N1 receiver. It adds selectable parity (none/even/odd), 1 or 2 stop bits, false-start rejection, an input synchroniser, per-frame error flags, break detection and a valid/ready output holding register with overrun reporting. It sits between the pad-side `rx` line and the bus/FIFO logic, and is clocked by `clk` with a shared baud generator supplying `s_tick`.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_sync2.sv | 16 +
 rtl/uart_rx_cfg.sv | 134 +++++++++++++
 tb/tb_uart_rx_cfg.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, parity encodings and defaults for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} uart_rx_state_t;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam int OS_DEFAULT = 16;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous single-bit input
// ports: clk, reset_n (async active-low), d (async in), q (synchronised out, RST_VAL in reset)
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {q, meta} <= {RST_VAL, RST_VAL};
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (parity, 1/2 stop bits, break, holding register)
// ports: clk, reset_n (async active-low), rx (async serial in), s_tick (OS x baud strobe),
//   parity_mode/stop2 (frame format, latched at frame start), rx_ready (consumer accept),
//   rx_dout/rx_valid/parity_err/frame_err/overrun_err (held word), break_det (pulse), rx_busy
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OS   = OS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    input  logic [1:0]      parity_mode,
    input  logic            stop2,
    input  logic            rx_ready,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_valid,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overrun_err,
    output logic            break_det,
    output logic            rx_busy
);
    localparam int SW = $clog2(OS);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    if (DBIT < 5 || DBIT > 9) begin : g_dbit_chk
        $error("uart_rx_cfg: DBIT must be in 5..9");
    end
    if (OS < 8 || (OS & (OS - 1)) != 0) begin : g_os_chk
        $error("uart_rx_cfg: OS must be a power of 2, at least 8");
    end
    uart_rx_state_t  state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] sh;
    logic [1:0]      par_q;
    logic            stop2_q, sec, pz, perr, ferr, rxs;
    logic            par_en, last, in_stop, brk, fin;
    uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset_n(reset_n), .d(rx), .q(rxs));
    assign par_en  = par_q == PAR_EVEN || par_q == PAR_ODD;
    assign last    = s_tick && s == S_LAST;
    assign in_stop = state == STOP && last;
    // pz: parity bit was 0 (or absent), so an all-zero first stop sample means break
    assign brk     = in_stop && !sec && !rxs && pz && sh == '0;
    assign fin     = in_stop && (brk || !stop2_q || sec);
    assign rx_busy = state != IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            sh          <= '0;
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            sec         <= 1'b0;
            pz          <= 1'b0;
            perr        <= 1'b0;
            ferr        <= 1'b0;
            rx_dout     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            break_det <= brk;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (fin) begin
                if (!rx_valid || rx_ready) begin
                    rx_dout     <= sh;
                    parity_err  <= perr;
                    frame_err   <= ferr | ~rxs;
                    rx_valid    <= 1'b1;
                    overrun_err <= 1'b0;
                end else begin
                    overrun_err <= 1'b1;
                end
            end
            // in DATA/PARITY/STOP, s wraps from OS-1 to 0 on its own since OS is a power of 2
            case (state)
                IDLE: if (!rxs) begin
                    s       <= '0;
                    par_q   <= parity_mode;
                    stop2_q <= stop2;
                    state   <= START;
                end
                START: if (s_tick) begin
                    if (s != S_MID) s <= s + 1'b1;
                    else if (rxs) state <= IDLE;
                    else begin
                        s     <= '0;
                        n     <= '0;
                        perr  <= 1'b0;
                        ferr  <= 1'b0;
                        sec   <= 1'b0;
                        pz    <= 1'b1;
                        state <= DATA;
                    end
                end
                DATA: if (s_tick) begin
                    s <= s + 1'b1;
                    if (s == S_LAST) begin
                        sh <= {rxs, sh[DBIT-1:1]};
                        n  <= n + 1'b1;
                        if (n == N_LAST) state <= par_en ? PARITY : STOP;
                    end
                end
                PARITY: if (s_tick) begin
                    s <= s + 1'b1;
                    if (s == S_LAST) begin
                        perr  <= ^sh ^ rxs ^ (par_q == PAR_ODD);
                        pz    <= ~rxs;
                        state <= STOP;
                    end
                end
                STOP: if (s_tick) begin
                    s <= s + 1'b1;
                    if (s == S_LAST) begin
                        ferr  <= ferr | ~rxs;
                        sec   <= 1'b1;
                        state <= brk ? BRK_WAIT : fin ? IDLE : STOP;
                    end
                end
                BRK_WAIT: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg (DBIT=8 and DBIT=7 instances)
module tb_uart_rx_cfg;
    typedef struct packed {logic [8:0] d; logic p; logic f; logic o;} exp_t;
    logic       clk = 1'b0, reset_n = 1'b0, rx_line = 1'b1, sel7 = 1'b0, rx_ready = 1'b0, stop2 = 1'b0;
    logic [1:0] parity_mode = 2'b00, tcnt = 2'b00;
    logic       s_tick, rx8, rx7;
    logic [7:0] dout8;
    logic [6:0] dout7;
    logic       v8, pe8, fe8, oe8, bd8, busy8, v7, pe7, fe7, oe7, bd7, busy7;
    exp_t       q[$];
    exp_t       e;
    int         total = 0, bad = 0, brk_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tcnt <= tcnt + 2'd1;
    assign s_tick = tcnt == 2'd3;
    assign rx8 = sel7 ? 1'b1 : rx_line;
    assign rx7 = sel7 ? rx_line : 1'b1;
    always @(negedge clk) if (bd8) brk_cnt++;

    uart_rx_cfg #(.DBIT(8), .OS(16)) dut8 (
        .clk(clk), .reset_n(reset_n), .rx(rx8), .s_tick(s_tick), .parity_mode(parity_mode),
        .stop2(stop2), .rx_ready(rx_ready), .rx_dout(dout8), .rx_valid(v8), .parity_err(pe8),
        .frame_err(fe8), .overrun_err(oe8), .break_det(bd8), .rx_busy(busy8)
    );
    uart_rx_cfg #(.DBIT(7), .OS(16)) dut7 (
        .clk(clk), .reset_n(reset_n), .rx(rx7), .s_tick(s_tick), .parity_mode(parity_mode),
        .stop2(stop2), .rx_ready(rx_ready), .rx_dout(dout7), .rx_valid(v7), .parity_err(pe7),
        .frame_err(fe7), .overrun_err(oe7), .break_det(bd7), .rx_busy(busy7)
    );

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one bit = 64 clk = 16 ticks; a trailing 0 stop bit is cut short after its centre
    task automatic send_frame(input logic [8:0] d, input int nb, input int par,
                              input logic [1:0] stops, input int ns);
        rx_line = 1'b0;
        cycles(64);
        for (int i = 0; i < nb; i++) begin
            rx_line = d[i];
            cycles(64);
        end
        if (par >= 0) begin
            rx_line = par[0];
            cycles(64);
        end
        for (int i = 0; i < ns; i++) begin
            rx_line = stops[i];
            cycles((!stops[i] && i == ns - 1) ? 40 : 64);
        end
        rx_line = 1'b1;
        cycles(64);
    endtask

    task automatic wait_valid(input string name);
        int i;
        for (i = 0; i < 2000 && !(sel7 ? v7 : v8); i++) cycles(1);
        if (i == 2000) begin
            total++;
            bad++;
            $display("FAIL %s: rx_valid timeout, got 0 need 1", name);
        end
    endtask

    task automatic ack();
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        cycles(3);
        total++;
        if ({dout8, v8, pe8, fe8, oe8, bd8, busy8} !== 14'b0) begin
            bad++;
            $display("FAIL reset_in: got %h need 0", {dout8, v8, pe8, fe8, oe8, bd8, busy8});
        end
        reset_n = 1'b1;
        cycles(5);
        total++;
        if ({dout8, v8, pe8, fe8, oe8, bd8, busy8} !== 14'b0) begin
            bad++;
            $display("FAIL reset_out: got %h need 0", {dout8, v8, pe8, fe8, oe8, bd8, busy8});
        end
    endtask

    task automatic test_8n1();
        q.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0});
        send_frame(9'h0A5, 8, -1, 2'b11, 1);
        wait_valid("8n1");
        e = q.pop_front();
        total++;
        if ({dout8, pe8, fe8, oe8} !== {e.d[7:0], e.p, e.f, e.o}) begin
            bad++;
            $display("FAIL 8n1: got %h need %h", {dout8, pe8, fe8, oe8}, {e.d[7:0], e.p, e.f, e.o});
        end
        ack();
        total++;
        if (v8 !== 1'b0) begin
            bad++;
            $display("FAIL 8n1_ready: rx_valid got %b need 0", v8);
        end
    endtask

    task automatic test_parity();
        sel7 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            parity_mode = (k == 2) ? 2'b10 : 2'b01;
            q.push_back('{9'h055, logic'(k == 0), 1'b0, 1'b0});
            send_frame(9'h055, 7, (k == 1) ? 0 : 1, 2'b11, 1);
            wait_valid("parity");
            e = q.pop_front();
            total++;
            if ({dout7, pe7, fe7, oe7} !== {e.d[6:0], e.p, e.f, e.o}) begin
                bad++;
                $display("FAIL parity%0d: got %h need %h", k, {dout7, pe7, fe7, oe7}, {e.d[6:0], e.p, e.f, e.o});
            end
            ack();
        end
        sel7 = 1'b0;
        parity_mode = 2'b00;
    endtask

    task automatic test_stop2();
        stop2 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q.push_back('{(k == 0) ? 9'h03C : 9'h0C3, 1'b0, logic'(k == 0), 1'b0});
            send_frame((k == 0) ? 9'h03C : 9'h0C3, 8, -1, (k == 0) ? 2'b01 : 2'b11, 2);
            wait_valid("stop2");
            e = q.pop_front();
            total++;
            if ({dout8, pe8, fe8, oe8} !== {e.d[7:0], e.p, e.f, e.o}) begin
                bad++;
                $display("FAIL stop2_%0d: got %h need %h", k, {dout8, pe8, fe8, oe8}, {e.d[7:0], e.p, e.f, e.o});
            end
            ack();
        end
        stop2 = 1'b0;
    endtask

    task automatic test_glitch();
        rx_line = 1'b0;
        cycles(16);
        rx_line = 1'b1;
        cycles(60);
        total++;
        if (busy8 !== 1'b0 || v8 !== 1'b0) begin
            bad++;
            $display("FAIL glitch: busy=%b valid=%b need 0 0", busy8, v8);
        end
        q.push_back('{9'h081, 1'b0, 1'b0, 1'b0});
        send_frame(9'h081, 8, -1, 2'b11, 1);
        wait_valid("glitch_frame");
        e = q.pop_front();
        total++;
        if ({dout8, pe8, fe8, oe8} !== {e.d[7:0], e.p, e.f, e.o}) begin
            bad++;
            $display("FAIL glitch_frame: got %h need %h", {dout8, pe8, fe8, oe8}, {e.d[7:0], e.p, e.f, e.o});
        end
        ack();
    endtask

    task automatic test_break();
        int b0 = brk_cnt;
        q.push_back('{9'h000, 1'b0, 1'b1, 1'b0});
        rx_line = 1'b0;
        wait_valid("break");
        e = q.pop_front();
        total++;
        if ({dout8, pe8, fe8, oe8} !== {e.d[7:0], e.p, e.f, e.o}) begin
            bad++;
            $display("FAIL break: got %h need %h", {dout8, pe8, fe8, oe8}, {e.d[7:0], e.p, e.f, e.o});
        end
        ack();
        cycles(700);
        total++;
        if (v8 !== 1'b0 || busy8 !== 1'b1) begin
            bad++;
            $display("FAIL break_hold: valid=%b busy=%b need 0 1", v8, busy8);
        end
        rx_line = 1'b1;
        cycles(64);
        total++;
        if (busy8 !== 1'b0) begin
            bad++;
            $display("FAIL break_exit: busy got %b need 0", busy8);
        end
        total++;
        if (brk_cnt - b0 !== 1) begin
            bad++;
            $display("FAIL break_pulse: pulses got %0d need 1", brk_cnt - b0);
        end
    endtask

    task automatic test_overrun();
        q.push_back('{9'h011, 1'b0, 1'b0, 1'b1});
        send_frame(9'h011, 8, -1, 2'b11, 1);
        send_frame(9'h022, 8, -1, 2'b11, 1);
        wait_valid("overrun");
        e = q.pop_front();
        total++;
        if ({dout8, pe8, fe8, oe8} !== {e.d[7:0], e.p, e.f, e.o}) begin
            bad++;
            $display("FAIL overrun: got %h need %h", {dout8, pe8, fe8, oe8}, {e.d[7:0], e.p, e.f, e.o});
        end
        ack();
        total++;
        if (v8 !== 1'b0) begin
            bad++;
            $display("FAIL overrun_ack: rx_valid got %b need 0", v8);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(9'h033, 8, -1, 2'b11, 1);
        total++;
        if (v8 !== 1'b1) begin
            bad++;
            $display("FAIL held: rx_valid got %b need 1", v8);
        end
        rx_line = 1'b0;
        cycles(264);
        total++;
        if (busy8 !== 1'b1) begin
            bad++;
            $display("FAIL mid_data: busy got %b need 1", busy8);
        end
        reset_n = 1'b0;
        cycles(2);
        total++;
        if ({dout8, v8, pe8, fe8, oe8, bd8, busy8} !== 14'b0) begin
            bad++;
            $display("FAIL reset_mid: got %h need 0", {dout8, v8, pe8, fe8, oe8, bd8, busy8});
        end
        rx_line = 1'b1;
        cycles(2);
        reset_n = 1'b1;
        cycles(64);
        q.push_back('{9'h07E, 1'b0, 1'b0, 1'b0});
        send_frame(9'h07E, 8, -1, 2'b11, 1);
        wait_valid("after_reset");
        e = q.pop_front();
        total++;
        if ({dout8, pe8, fe8, oe8} !== {e.d[7:0], e.p, e.f, e.o}) begin
            bad++;
            $display("FAIL after_reset: got %h need %h", {dout8, pe8, fe8, oe8}, {e.d[7:0], e.p, e.f, e.o});
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        total++;
        if (q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard: leftover got %0d need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
